disp_scan: RTL
==============

Name: disp_scan

Overview:
- Time-multiplexed 4-digit 7-segment scanner, directly downstream of the stopwatch segment decoders.
- Consumes the four 8-bit segment patterns (sec1, sec2, min1, min2 order) and drives one shared 8-bit segment bus plus four active-low digit anodes.
- Inserts an anti-ghosting guard interval between digits.
- Snapshots all four patterns once per frame so a frame never mixes digits from two different counts.

Parameters:
- REFRESH_CYCLES, 50_000, clk cycles per digit slot (1 kHz per digit at 50 MHz); must be >= 2.
- GUARD_CYCLES, 500, cycles at the start of each slot with all anodes off; must satisfy 1 <= GUARD_CYCLES < REFRESH_CYCLES.
- BLANK, 8'hFF, segment pattern driven when nothing is lit.
- BLINK_CYCLES, 25_000_000, half-period of the blink phase; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- en  input  1  scan enable.
- blink  input  1  blink request; ignored unless DISP_SCAN_BLINK_EN is defined.
- segment1  input  8  pattern for digit 0 (sec1).
- segment2  input  8  pattern for digit 1 (sec2).
- segment3  input  8  pattern for digit 2 (min1).
- segment4  input  8  pattern for digit 3 (min2).
- seg_out  output  8  shared segment bus (registered).
- an  output  4  digit anodes, active-low one-hot (registered).
- frame_tick  output  1  one-cycle pulse when a full 4-digit frame completes (registered).

Behaviour:
- State:
  - cnt: 0..REFRESH_CYCLES-1, slot cycle counter.
  - idx: 0..3, current digit.
  - snap[0..3]: 8-bit snapshot registers.
- Reset (rst==0 at a clk edge): cnt=0, idx=0, snap[*]=BLANK, seg_out=BLANK, an=4'b1111, frame_tick=0. Reset mid-slot aborts immediately, with no partial-slot completion.
- Counter rules (en==1):
  - cnt increments each cycle.
  - At cnt==REFRESH_CYCLES-1: cnt wraps to 0 and idx advances (3 wraps to 0).
  - frame_tick=1 on the edge where idx wraps 3->0; 0 otherwise.
- Snapshot: every edge where cnt==0 and idx==0, snap[0..3] load segment1..segment4. This also happens on the first enabled cycle after reset.
- Output registers are updated every edge from the pre-edge cnt, idx and snap values, giving one cycle of latency:
  - cnt < GUARD_CYCLES: an=4'b1111, seg_out=BLANK.
  - otherwise: an = ~(4'b0001 << idx), seg_out = snap[idx].
- Input changes mid-frame are not visible until the next frame's snapshot.
- en==0: cnt=0, idx=0, an=4'b1111, seg_out=BLANK, frame_tick=0.
  - snap reloads every cycle, because cnt==0 and idx==0.
  - Re-enabling starts a fresh frame at digit 0 with a full guard interval.
- Exactly one anode is low at any time, or none. Never two.
- No arithmetic overflow: cnt is sized with $clog2(REFRESH_CYCLES) bits.

Optional Feature:
- Macro: DISP_SCAN_BLINK_EN.
- Defined:
  - Adds a blink counter 0..BLINK_CYCLES-1 and a phase bit.
  - Phase toggles on each counter wrap; reset sets counter=0 and phase=0.
  - Counter runs regardless of en.
  - While blink==1 and phase==1: an=4'b1111 and seg_out=BLANK.
  - Scan counters, snapshot and frame_tick continue unaffected.
- Not defined: no blink counter or phase logic; the blink port exists but is ignored.

Test Plan (REFRESH_CYCLES=8, GUARD_CYCLES=2, BLINK_CYCLES=16 unless noted):
- Reset: hold rst=0 for 3 cycles with en=1 and arbitrary inputs -> an=4'b1111, seg_out=8'hFF, frame_tick=0 throughout.
- Basic scan: release rst, en=1, segment1..4 = 8'hC0, 8'hF9, 8'hA4, 8'hB0 -> an=1111 for edges 1..2; an=1110 with seg_out=C0 for edges 3..8; then an=1101/F9 for edges 11..16, and so on. frame_tick pulses once every 32 cycles.
- Snapshot coherence: change segment1 to 8'h99 while idx==2 -> digit 0 keeps showing C0 for the rest of the frame and shows 99 from the next frame on.
- Enable drop: deassert en while idx==2 and cnt==5 -> next edge an=1111, seg_out=FF. Re-assert en -> digit 0 is lit again after 2 guard cycles plus 1 cycle of latency.
- Mid-operation reset: assert rst=0 for 1 cycle while idx==3 -> an=1111 and idx restarts at 0. No frame_tick pulse for the aborted frame.
- Blink (macro defined): blink=1 -> output is blanked for 16 cycles out of every 32 while frame_tick cadence is unchanged. With blink=0, or with the macro undefined, the output is identical to the basic scan case.

Source files
------------

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed 4-digit 7-segment scanner.
//
// Snapshots the four digit patterns at the start of each frame. It then walks
// digits 0..3 and gives each digit one slot of REFRESH_CYCLES clocks. The first
// GUARD_CYCLES clocks of every slot are blanked to avoid ghosting.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   en         scan enable; when low, holds the scanner at digit 0 with everything dark
//   blink      blink request (used only when DISP_SCAN_BLINK_EN is defined)
//   segment1   pattern for digit 0 (sec1)
//   segment2   pattern for digit 1 (sec2)
//   segment3   pattern for digit 2 (min1)
//   segment4   pattern for digit 3 (min2)
//   seg_out    shared segment bus (registered)
//   an         active-low one-hot digit anodes (registered)
//   frame_tick one-cycle pulse when a full 4-digit frame completes (registered)
//
// Optional feature: define DISP_SCAN_BLINK_EN to add a free-running blink phase.
// The phase blanks the display while blink is high (BLINK_CYCLES >= 2 is assumed).
module disp_scan #(
  parameter int unsigned REFRESH_CYCLES = 50_000,
  parameter int unsigned GUARD_CYCLES   = 500,
  parameter logic [7:0]  BLANK          = 8'hFF,
  parameter int unsigned BLINK_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       blink,
  input  logic [7:0] segment1,
  input  logic [7:0] segment2,
  input  logic [7:0] segment3,
  input  logic [7:0] segment4,
  output logic [7:0] seg_out,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int unsigned     CntW   = $clog2(REFRESH_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_CYCLES - 1);
  localparam logic [CntW-1:0] Guard  = CntW'(GUARD_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      snap_q [4];
  logic [7:0]      seg_d;
  logic [3:0]      an_d;
  logic            tick_d;
  logic            snap_load;
  logic            blank_force;

  // Frame start: latch all four digits together so a frame never mixes two counts.
  assign snap_load = (cnt_q == '0) && (idx_q == 2'd0);

`ifdef DISP_SCAN_BLINK_EN
  localparam int unsigned      BlkW   = $clog2(BLINK_CYCLES);
  localparam logic [BlkW-1:0]  BlkMax = BlkW'(BLINK_CYCLES - 1);

  logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
  logic            phase_q, phase_d;

  // Free-running, independent of en, so the blink cadence stays steady.
  always_comb begin
    blk_cnt_d = blk_cnt_q + BlkW'(1);
    phase_d   = phase_q;
    if (blk_cnt_q == BlkMax) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign blank_force = blink & phase_q;
`else
  logic unused_blink;
  assign unused_blink = blink | (BLINK_CYCLES == 32'd0);
  assign blank_force  = 1'b0;
`endif

  always_comb begin
    cnt_d  = '0;
    idx_d  = 2'd0;
    tick_d = 1'b0;
    an_d   = 4'b1111;
    seg_d  = BLANK;
    if (en) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        idx_d  = idx_q + 2'd1;
        tick_d = (idx_q == 2'd3);
      end else begin
        cnt_d = cnt_q + CntW'(1);
        idx_d = idx_q;
      end
      if (cnt_q >= Guard) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = snap_q[idx_q];
      end
    end
    if (blank_force) begin
      an_d  = 4'b1111;
      seg_d = BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      snap_q[0]  <= BLANK;
      snap_q[1]  <= BLANK;
      snap_q[2]  <= BLANK;
      snap_q[3]  <= BLANK;
      seg_out    <= BLANK;
      an         <= 4'b1111;
      frame_tick <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_out    <= seg_d;
      an         <= an_d;
      frame_tick <= tick_d;
      if (snap_load) begin
        snap_q[0] <= segment1;
        snap_q[1] <= segment2;
        snap_q[2] <= segment3;
        snap_q[3] <= segment4;
      end
    end
  end

endmodule
